// File: rtl/adder.sv
// ----------------------------------------------------------------------------
// adder: two-stage pipelined three-operand unsigned adder.
//
// Computes in1 + in2 + in3 at full precision (WIDTH+2 bits). Stage 1 compresses
// the three operands to a sum/carry pair with a row of 3:2 counters; stage 2
// resolves that pair with a parallel-prefix carry-propagate adder. A valid bit
// travels with the data, so latency is exactly two cycles and gaps in in_valid
// reappear unchanged on out_valid. Data registers hold when their stage is
// idle, so the outputs keep the last result between valid pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears every pipeline register
//   in_valid   operand set on in1/in2/in3 is valid this cycle
//   in1..in3   unsigned operands, WIDTH bits each
//   sum        low WIDTH bits of the full sum
//   sum_hi     bits WIDTH+1:WIDTH of the full sum
//   overflow   full sum does not fit in WIDTH bits (sum_hi != 0)
//   out_valid  sum/sum_hi/overflow carry a fresh result this cycle
// ----------------------------------------------------------------------------
module adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] sum,
    output logic [1:0]       sum_hi,
    output logic             overflow,
    output logic             out_valid
);

    // Three WIDTH-bit operands sum to at most 3*(2^WIDTH-1), which needs WIDTH+2 bits.
    localparam int FullW = int'(WIDTH) + 2;

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("adder: WIDTH must be in 2..64");
    end

    // ------------------------------------------------------------------------
    // Parallel-prefix (Kogge-Stone) adder over FullW bits, carry-in zero.
    // Each level doubles the span of the (generate, propagate) groups; after
    // ceil(log2(FullW)) levels g[i] is the carry out of bits [i:0].
    // ------------------------------------------------------------------------
    function automatic logic [FullW-1:0] prefix_add(input logic [FullW-1:0] a,
                                                    input logic [FullW-1:0] b);
        logic [FullW-1:0] g;
        logic [FullW-1:0] p;
        logic [FullW-1:0] g_n;
        logic [FullW-1:0] p_n;
        logic [FullW-1:0] half;
        g    = a & b;
        p    = a ^ b;
        half = p;
        for (int l = 0; (1 << l) < FullW; l++) begin
            g_n = g;
            p_n = p;
            for (int i = (1 << l); i < FullW; i++) begin
                g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
                p_n[i] = p[i] & p[i - (1 << l)];
            end
            g = g_n;
            p = p_n;
        end
        // Carry into bit i is the group generate of bits [i-1:0].
        return half ^ {g[FullW-2:0], 1'b0};
    endfunction

    // ------------------------------------------------------------------------
    // Stage 1: carry-save compression
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] s_d;
    logic [WIDTH:0]   c_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH:0]   c_q;
    logic             v1_q;

    always_comb begin
        s_d = in1 ^ in2 ^ in3;
        // Majority is the carry out of each bit position, so it weighs one bit higher.
        c_d = {(in1 & in2) | (in1 & in3) | (in2 & in3), 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            c_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                s_q <= s_d;
                c_q <= c_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: carry-propagate add of the sum/carry pair
    // ------------------------------------------------------------------------
    logic [FullW-1:0] full_d;
    logic [WIDTH-1:0] sum_q;
    logic [1:0]       sum_hi_q;
    logic             overflow_q;
    logic             out_valid_q;

    always_comb begin
        full_d = prefix_add({2'b00, s_q}, {1'b0, c_q});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            sum_hi_q    <= 2'b00;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                sum_q      <= full_d[WIDTH-1:0];
                sum_hi_q   <= full_d[FullW-1:WIDTH];
                overflow_q <= |full_d[FullW-1:WIDTH];
            end
        end
    end

    assign sum       = sum_q;
    assign sum_hi    = sum_hi_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder.sv
// ----------------------------------------------------------------------------
// tb_adder: directed and randomized checks of the three-operand pipelined adder.
// The reference keeps a queue of promised results, each tagged with the clock
// edge after which it must appear; reset empties the queue and zeroes the held
// output value.
// ----------------------------------------------------------------------------
module tb_adder;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] in3;
    logic [W-1:0] sum;
    logic [1:0]   sum_hi;
    logic         overflow;
    logic         out_valid;

    adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .sum      (sum),
        .sum_hi   (sum_hi),
        .overflow (overflow),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W+1:0] val;
    } pending_t;

    pending_t     pend[$];
    int           edge_n = 0;
    logic [W+1:0] held   = '0;
    logic         exp_v  = 1'b0;
    int           n_vec  = 0;
    int           n_err  = 0;

    task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s (edge %0d): observed %h expected %h", tag, edge_n, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the reference, then check all outputs.
    task automatic tick(input logic r, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c);
        rst      = r;
        in_valid = v;
        in1      = a;
        in2      = b;
        in3      = c;
        @(posedge clk);
        edge_n++;
        exp_v = 1'b0;
        if (r) begin
            pend.delete();
            held = '0;
        end else begin
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                held  = pend[0].val;
                exp_v = 1'b1;
                void'(pend.pop_front());
            end
            if (v) pend.push_back('{due: edge_n + 1,
                                   val: {2'b00, a} + {2'b00, b} + {2'b00, c}});
        end
        #1;
        check("out_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, exp_v});
        check("sum",       {2'b00, sum},               {2'b00, held[W-1:0]});
        check("sum_hi",    {{W{1'b0}}, sum_hi},        {{W{1'b0}}, held[W+1:W]});
        check("overflow",  {{(W+1){1'b0}}, overflow},  {{(W+1){1'b0}}, (held[W+1:W] != 2'b00)});
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, $urandom, $urandom, $urandom);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return W'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W-1:0] ones;
        ones = '1;

        // Reset for two cycles
        tick(1'b1, 1'b0, '0, '0, '0);
        tick(1'b1, 1'b0, '0, '0, '0);

        // Basic sum 10+20+20, then hold of 50
        tick(1'b0, 1'b1, 10, 20, 20);
        idle();
        idle();
        idle();

        // Maximum operands and single wrap
        tick(1'b0, 1'b1, ones, ones, ones);
        tick(1'b0, 1'b1, ones, 1, 0);
        idle();
        idle();

        // Streaming
        tick(1'b0, 1'b1, 1, 2, 3);
        tick(1'b0, 1'b1, 4, 5, 6);
        tick(1'b0, 1'b1, 7, 8, 9);
        tick(1'b0, 1'b1, 0, 0, 0);
        idle();
        idle();
        idle();

        // Valid gaps: the invalid set (99,99,99) must not appear
        tick(1'b0, 1'b1, 1, 1, 1);
        tick(1'b0, 1'b0, 99, 99, 99);
        tick(1'b0, 1'b1, 2, 2, 2);
        idle();
        idle();
        idle();

        // Reset one edge after presenting (5,5,5): no result for it
        tick(1'b0, 1'b1, 5, 5, 5);
        tick(1'b1, 1'b0, '0, '0, '0);
        idle();
        idle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 rand_op(), rand_op(), rand_op());
        end
        idle();
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
